// File: rtl/cp_pkg.sv
// Shared types and constants for the cyclic-prefix inserter.
// The width helper never returns 0, so an index bus always has at least one bit.
package cp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CP,
        BODY
    } phase_t;

    localparam int DW_DEF      = 16;
    localparam int NFFT_DEF    = 64;
    localparam int LCP_MAX_DEF = 16;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cp_inserter_if.sv
// Input and output sample streams of the CP inserter.
// The slave modport is the inserter's view; the master modport is its environment's view.
interface cp_inserter_if import cp_pkg::*; #(
    parameter int DW = DW_DEF
) ();

    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_re_i;
    logic [DW-1:0] in_im_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_re_o;
    logic [DW-1:0] out_im_o;
    logic          out_sos_o;
    logic          out_eos_o;

    modport slave (
        input  in_valid_i, in_re_i, in_im_i, out_ready_i,
        output in_ready_o, out_valid_o, out_re_o, out_im_o, out_sos_o, out_eos_o
    );

    modport master (
        output in_valid_i, in_re_i, in_im_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_re_o, out_im_o, out_sos_o, out_eos_o
    );

endinterface

// File: rtl/cp_bank_ram.sv
// One symbol bank: register array with a synchronous write port
// and a combinational read port.
module cp_bank_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          CLK_I,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK_I) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: ping-pong buffers whole symbols, then replays the
// last cl samples followed by the full symbol, with backpressure on both sides.
module cp_inserter import cp_pkg::*; #(
    parameter int DW      = DW_DEF,
    parameter int NFFT    = NFFT_DEF,
    parameter int LCP_MAX = LCP_MAX_DEF,
    parameter int AW      = width_of(NFFT),
    parameter int CW      = width_of(LCP_MAX + 1)
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [CW-1:0] cp_len_i,
    input  logic          flush_i,
    cp_inserter_if.slave  bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);
    localparam logic [CW-1:0] CL_MAX   = CW'(LCP_MAX);

    logic [1:0]      full;
    logic            wr_bank;
    logic [AW-1:0]   wr_idx;
    logic            accept;

    phase_t          phase, phase_nxt;
    logic            rd_bank, rd_bank_nxt;
    logic [AW-1:0]   rd_idx, rd_idx_nxt;
    logic            ld;
    logic            load;
    logic            load_sos;
    logic            load_eos;
    logic            release_bank;
    logic [AW-1:0]   load_idx;
    logic [CW-1:0]   cl;

    logic [2*DW-1:0] rdata [2];
    logic [2*DW-1:0] rd_word;

    assign bus.in_ready_o = !full[wr_bank];
    assign accept         = bus.in_valid_i && bus.in_ready_o && !flush_i;
    assign rd_word        = rdata[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cp_bank_ram #(
            .W     (2*DW),
            .DEPTH (NFFT),
            .AW    (AW)
        ) u_ram (
            .CLK_I (CLK_I),
            .we    (accept && (int'(wr_bank) == b)),
            .waddr (wr_idx),
            .wdata ({bus.in_re_i, bus.in_im_i}),
            .raddr (load_idx),
            .rdata (rdata[b])
        );
    end

    // Full flags are set by the writer and cleared by the reader; the two never target the same bank.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (flush_i) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else begin
            if (accept) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (accept && (wr_idx == LAST_IDX) && (int'(wr_bank) == b)) begin
                    full[b] <= 1'b1;
                end else if (release_bank && (int'(rd_bank) == b)) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // IDLE already loads the first sample of a symbol, so back-to-back symbols leave no gap.
    always_comb begin
        ld           = !bus.out_valid_o || bus.out_ready_i;
        cl           = (cp_len_i > CL_MAX) ? CL_MAX : cp_len_i;
        phase_nxt    = phase;
        rd_idx_nxt   = rd_idx;
        rd_bank_nxt  = rd_bank;
        load         = 1'b0;
        load_idx     = rd_idx;
        load_sos     = 1'b0;
        load_eos     = 1'b0;
        release_bank = 1'b0;
        case (phase)
            IDLE: begin
                if (full[rd_bank] && ld) begin
                    load     = 1'b1;
                    load_sos = 1'b1;
                    if (cl == '0) begin
                        load_idx   = '0;
                        phase_nxt  = BODY;
                        rd_idx_nxt = AW'(1);
                    end else begin
                        load_idx = AW'(NFFT - int'(cl));
                        if (load_idx == LAST_IDX) begin
                            phase_nxt  = BODY;
                            rd_idx_nxt = '0;
                        end else begin
                            phase_nxt  = CP;
                            rd_idx_nxt = load_idx + 1'b1;
                        end
                    end
                end
            end
            CP: begin
                if (ld) begin
                    load = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        phase_nxt  = BODY;
                        rd_idx_nxt = '0;
                    end else begin
                        rd_idx_nxt = rd_idx + 1'b1;
                    end
                end
            end
            BODY: begin
                if (ld) begin
                    load = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        load_eos     = 1'b1;
                        release_bank = 1'b1;
                        rd_bank_nxt  = !rd_bank;
                        phase_nxt    = IDLE;
                        rd_idx_nxt   = '0;
                    end else begin
                        rd_idx_nxt = rd_idx + 1'b1;
                    end
                end
            end
            default: phase_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase   <= IDLE;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else if (flush_i) begin
            phase   <= IDLE;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            rd_idx  <= rd_idx_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            bus.out_valid_o <= 1'b0;
            bus.out_sos_o   <= 1'b0;
            bus.out_eos_o   <= 1'b0;
            bus.out_re_o    <= '0;
            bus.out_im_o    <= '0;
        end else if (flush_i) begin
            bus.out_valid_o <= 1'b0;
            bus.out_sos_o   <= 1'b0;
            bus.out_eos_o   <= 1'b0;
        end else if (ld) begin
            bus.out_valid_o <= load;
            bus.out_sos_o   <= load && load_sos;
            bus.out_eos_o   <= load && load_eos;
            if (load) begin
                bus.out_re_o <= rd_word[2*DW-1:DW];
                bus.out_im_o <= rd_word[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cp_inserter.sv
// Directed bench for cp_inserter: a symbol-level reference queue is checked
// against every output handshake, plus literal checks at key points.
module tb_cp_inserter;
    import cp_pkg::*;

    localparam int DW      = 16;
    localparam int NFFT    = 64;
    localparam int LCP_MAX = 16;
    localparam int CW      = width_of(LCP_MAX + 1);

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sos;
        logic          eos;
    } exp_t;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic [CW-1:0] cp_len;
    logic          flush;
    logic          rand_en;
    logic          ready_fixed;

    cp_inserter_if #(.DW(DW)) bus ();

    cp_inserter #(
        .DW      (DW),
        .NFFT    (NFFT),
        .LCP_MAX (LCP_MAX)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .cp_len_i (cp_len),
        .flush_i  (flush),
        .bus      (bus.slave)
    );

    always #5 CLK_I = ~CLK_I;

    always begin
        @(posedge CLK_I);
        #2;
        bus.out_ready_i = rand_en ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    int checks = 0;
    int errors = 0;

    exp_t          expq[$];
    logic [DW-1:0] part_re [NFFT];
    logic [DW-1:0] part_im [NFFT];
    int            part_cnt;
    int            acc_count;
    int            out_count;
    int            sos_count;
    int            eos_count;
    int            cycle;
    int            hs_first;
    int            hs_last;
    int            hs_n;
    int            last_eos_re;

    // Reference: a completed input symbol becomes its last cl samples followed by all NFFT samples.
    task automatic pushSymbol();
        int cl;
        cl = (int'(cp_len) > LCP_MAX) ? LCP_MAX : int'(cp_len);
        for (int i = NFFT - cl; i < NFFT; i++)
            expq.push_back('{re: part_re[i], im: part_im[i], sos: (i == NFFT - cl), eos: 1'b0});
        for (int i = 0; i < NFFT; i++)
            expq.push_back('{re: part_re[i], im: part_im[i], sos: (cl == 0 && i == 0), eos: (i == NFFT - 1)});
    endtask

    task automatic monitor();
        exp_t          e;
        logic          held_valid = 1'b0;
        logic [DW-1:0] held_re = '0, held_im = '0;
        logic          held_sos = 1'b0, held_eos = 1'b0;
        forever begin
            @(negedge CLK_I);
            cycle++;
            if (RST_I) begin
                expq.delete();
                part_cnt   = 0;
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    checks++;
                    if (!(bus.out_valid_o && bus.out_re_o == held_re && bus.out_im_o == held_im &&
                          bus.out_sos_o == held_sos && bus.out_eos_o == held_eos)) begin
                        errors++;
                        $display("[TB] FAIL stall_hold actual v=%0b re=%0d im=%0d sos=%0b eos=%0b required v=1 re=%0d im=%0d sos=%0b eos=%0b",
                                 bus.out_valid_o, bus.out_re_o, bus.out_im_o, bus.out_sos_o, bus.out_eos_o,
                                 held_re, held_im, held_sos, held_eos);
                    end
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL spurious_output actual re=%0d required no sample", bus.out_re_o);
                    end else begin
                        e = expq.pop_front();
                        if (bus.out_re_o !== e.re || bus.out_im_o !== e.im ||
                            bus.out_sos_o !== e.sos || bus.out_eos_o !== e.eos) begin
                            errors++;
                            $display("[TB] FAIL sample actual re=%0d im=%0d sos=%0b eos=%0b required re=%0d im=%0d sos=%0b eos=%0b",
                                     bus.out_re_o, bus.out_im_o, bus.out_sos_o, bus.out_eos_o,
                                     e.re, e.im, e.sos, e.eos);
                        end
                    end
                    out_count++;
                    if (bus.out_sos_o) sos_count++;
                    if (bus.out_eos_o) begin
                        eos_count++;
                        last_eos_re = int'(bus.out_re_o);
                    end
                    if (hs_n == 0) hs_first = cycle;
                    hs_last = cycle;
                    hs_n++;
                end
                held_valid = bus.out_valid_o && !bus.out_ready_i && !flush;
                held_re    = bus.out_re_o;
                held_im    = bus.out_im_o;
                held_sos   = bus.out_sos_o;
                held_eos   = bus.out_eos_o;
                if (bus.in_valid_i && bus.in_ready_o && !flush) begin
                    part_re[part_cnt] = bus.in_re_i;
                    part_im[part_cnt] = bus.in_im_i;
                    part_cnt++;
                    acc_count++;
                    if (part_cnt == NFFT) begin
                        pushSymbol();
                        part_cnt = 0;
                    end
                end
                if (flush) begin
                    expq.delete();
                    part_cnt = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Sends n ramp samples base.. (im = -re); at index flush_at the sample goes out with flush and sending stops.
    task automatic applyStimulus(input int base, input int n, input int flush_at);
        int guard;
        for (int i = 0; i < n; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_re_i    = DW'(base + i);
            bus.in_im_i    = DW'(-(base + i));
            if (i == flush_at) begin
                flush = 1'b1;
                @(posedge CLK_I);
                #1;
                flush          = 1'b0;
                bus.in_valid_i = 1'b0;
                return;
            end
            guard = 0;
            while (!bus.in_ready_o && guard < 2000) begin
                @(posedge CLK_I);
                #1;
                guard++;
            end
            if (guard >= 2000) begin
                checks++;
                errors++;
                $display("[TB] FAIL in_ready_timeout actual=0 required=1");
                bus.in_valid_i = 1'b0;
                return;
            end
            @(posedge CLK_I);
            #1;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int guard = 0;
        while (!bus.out_valid_o && guard < 500) begin
            @(posedge CLK_I);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual out_valid=0 required=1", name);
        end
    endtask

    task automatic waitDrain(input string name);
        int guard = 0;
        while ((expq.size() != 0 || bus.out_valid_o) && guard < 3000) begin
            @(posedge CLK_I);
            #3;
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain_timeout actual pending=%0d required=0", name, expq.size());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int o0, s0, e0, a0;
        RST_I          = 1'b0;
        cp_len         = CW'(16);
        flush          = 1'b0;
        rand_en        = 1'b0;
        ready_fixed    = 1'b1;
        bus.in_valid_i = 1'b0;
        bus.in_re_i    = '0;
        bus.in_im_i    = '0;
        bus.out_ready_i = 1'b1;
        part_cnt = 0; acc_count = 0; out_count = 0; sos_count = 0; eos_count = 0;
        cycle = 0; hs_first = 0; hs_last = 0; hs_n = 0; last_eos_re = -1;
        fork
            monitor();
        join_none

        #2 RST_I = 1'b1;
        #10;
        checkOutput("rst_out_valid", 32'(bus.out_valid_o), 0);
        checkOutput("rst_sos_eos", {30'b0, bus.out_sos_o, bus.out_eos_o}, 0);
        checkOutput("rst_data", {bus.out_re_o, bus.out_im_o}, 0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        @(posedge CLK_I);
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready_o), 1);

        $display("[TB] cp_len=16 ramp");
        o0 = out_count; s0 = sos_count; e0 = eos_count;
        applyStimulus(0, 64, -1);
        checkOutput("latency_not_early", 32'(bus.out_valid_o), 0);
        @(posedge CLK_I);
        #1;
        checkOutput("latency_valid", 32'(bus.out_valid_o), 1);
        checkOutput("first_cp_re", 32'(bus.out_re_o), 48);
        checkOutput("first_cp_im", 32'(bus.out_im_o), 32'hFFD0);
        checkOutput("first_cp_sos", 32'(bus.out_sos_o), 1);
        waitDrain("ramp");
        checkOutput("ramp_len", 32'(out_count - o0), 80);
        checkOutput("ramp_sos", 32'(sos_count - s0), 1);
        checkOutput("ramp_eos", 32'(eos_count - e0), 1);
        checkOutput("ramp_eos_value", 32'(last_eos_re), 63);

        $display("[TB] bypass then clamped cp_len");
        cp_len = CW'(0);
        o0 = out_count;
        applyStimulus(0, 64, -1);
        waitValid("bypass");
        checkOutput("bypass_first_re", 32'(bus.out_re_o), 0);
        checkOutput("bypass_first_sos", 32'(bus.out_sos_o), 1);
        waitDrain("bypass");
        checkOutput("bypass_len", 32'(out_count - o0), 64);
        cp_len = CW'(20);
        o0 = out_count;
        applyStimulus(0, 64, -1);
        waitValid("clamp");
        checkOutput("clamp_first_re", 32'(bus.out_re_o), 48);
        waitDrain("clamp");
        checkOutput("clamp_len", 32'(out_count - o0), 80);

        $display("[TB] three symbols under backpressure");
        cp_len      = CW'(16);
        ready_fixed = 1'b0;
        @(posedge CLK_I);
        #3;
        a0 = acc_count;
        applyStimulus(0, 128, -1);
        repeat (3) @(posedge CLK_I);
        #1;
        checkOutput("bp_accepts", 32'(acc_count - a0), 128);
        checkOutput("bp_in_ready", 32'(bus.in_ready_o), 0);
        hs_n = 0;
        fork
            applyStimulus(128, 64, -1);
            begin
                repeat (5) @(posedge CLK_I);
                ready_fixed = 1'b1;
            end
        join
        waitDrain("bp");
        checkOutput("bp_out_count", 32'(hs_n), 240);
        checkOutput("bp_gap_free", 32'(hs_last - hs_first), 239);

        $display("[TB] random out_ready");
        cp_len  = CW'(8);
        s0 = sos_count; e0 = eos_count;
        rand_en = 1'b1;
        applyStimulus(0, 192, -1);
        repeat (200) @(posedge CLK_I);
        rand_en = 1'b0;
        waitDrain("random");
        checkOutput("random_sos", 32'(sos_count - s0), 3);
        checkOutput("random_eos", 32'(eos_count - e0), 3);

        $display("[TB] flush mid-output");
        cp_len = CW'(16);
        applyStimulus(0, 64, -1);
        applyStimulus(64, 64, 30);
        checkOutput("flush_out_valid", 32'(bus.out_valid_o), 0);
        checkOutput("flush_in_ready", 32'(bus.in_ready_o), 1);
        applyStimulus(128, 64, -1);
        waitValid("flush");
        checkOutput("flush_next_re", 32'(bus.out_re_o), 176);
        checkOutput("flush_next_sos", 32'(bus.out_sos_o), 1);
        waitDrain("flush");

        $display("[TB] reset mid-CP");
        applyStimulus(0, 64, -1);
        waitValid("rst_mid");
        repeat (3) @(posedge CLK_I);
        #3 RST_I = 1'b1;
        #1;
        checkOutput("rstmid_out_valid", 32'(bus.out_valid_o), 0);
        checkOutput("rstmid_flags", {30'b0, bus.out_sos_o, bus.out_eos_o}, 0);
        checkOutput("rstmid_data", {bus.out_re_o, bus.out_im_o}, 0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b0;
        @(posedge CLK_I);
        #1;
        applyStimulus(64, 64, -1);
        waitValid("post_rst");
        checkOutput("post_rst_re", 32'(bus.out_re_o), 112);
        checkOutput("post_rst_sos", 32'(bus.out_sos_o), 1);
        waitDrain("post_rst");
        checkOutput("queue_empty", 32'(expq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp_inserter.md
# cp_inserter

Parametrised cyclic-prefix inserter for the OFDM transmit chain, placed between the IFFT output and the DAC/upsampler stage. It accepts complex time-domain symbols of NFFT samples on a valid/ready stream and buffers them in a two-bank ping-pong memory. For each symbol it emits the last cp_len samples followed by all NFFT samples. Unlike the fixed 16/48 inserter, it has a single clock domain, full backpressure on both sides, a runtime-selectable CP length, a bypass mode and a flush.

## Interface
- DW, 16, sample width per I/Q component
- NFFT, 64, samples per symbol (≥ 2)
- LCP_MAX, 16, maximum CP length (1 ≤ LCP_MAX ≤ NFFT)
- AW, $clog2(NFFT), derived, sample index width
- CW, $clog2(LCP_MAX+1), derived, CP length width
- CLK_I  in  1  clock, rising edge
- RST_I  in  1  reset, asynchronous, active-high
- cp_len_i  in  CW  CP length; 0 = bypass; values > LCP_MAX are clamped to LCP_MAX
- flush_i  in  1  synchronous discard of all buffered and partial symbols
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  input sample accepted when valid & ready
- in_re_i, in_im_i  in  DW each  input sample I/Q
- out_valid_o  out  1  output register holds a sample
- out_ready_i  in  1  downstream accepts when valid & ready
- out_re_o, out_im_o  out  DW each  output sample I/Q
- out_sos_o  out  1  first output sample of a symbol (first CP sample, or sample 0 in bypass)
- out_eos_o  out  1  last output sample of a symbol (sample NFFT-1)

## Operation
- Storage: two banks, each NFFT × 2·DW. Each bank has a full flag; the writer has a bank select and wr_idx; the reader has a bank select, rd_idx and phase ∈ {IDLE, CP, BODY}.
- Writer: in_ready_o = !full[wr_bank]. On accept, write to bank[wr_bank][wr_idx] and increment wr_idx. At wr_idx == NFFT-1, set full[wr_bank], toggle wr_bank and set wr_idx = 0.
- Reader FSM. The load condition is ld = !out_valid_o | out_ready_i.
  - IDLE: if full[rd_bank] and ld, latch cl = min(cp_len_i, LCP_MAX).
    - If cl ≠ 0, go to CP with rd_idx = NFFT-cl.
    - If cl = 0, go to BODY with rd_idx = 0.
  - CP: each ld loads sample rd_idx. After loading NFFT-1, go to BODY with rd_idx = 0.
  - BODY: each ld loads sample rd_idx. After loading NFFT-1, clear full[rd_bank], toggle rd_bank and go to IDLE. If full[other bank] is already set, go directly to CP/BODY with a new cl, so there are no gap cycles.
- Output register: when ld and no sample is scheduled, out_valid_o drops to 0. out_sos_o/out_eos_o travel with the sample.
- cp_len_i is sampled only at symbol start. Changes during a symbol take effect on the next symbol.
- Simultaneous full-set (writer) and full-clear (reader) on different banks are independent. On the same bank this is impossible by construction.
- flush_i: clear both full flags, wr_idx, wr_bank, rd_bank, out_valid_o and phase → IDLE. Memory contents are not cleared. flush_i has priority over an accept in the same cycle, and the sample is dropped.

## Timing
- Reset values:
  - out_valid_o = 0, out_sos_o = 0, out_eos_o = 0, out_re_o/out_im_o = 0
  - in_ready_o = 1 once reset deasserts
  - all flags and indices = 0, phase = IDLE
- Latency: the last input sample of a symbol is accepted at edge k. out_valid_o rises after edge k+1, carrying the first CP sample.
- Throughput: one output per cycle under out_ready_i = 1. The output symbol is NFFT+cl samples. With continuous input at one sample per cycle and cl > 0, the input is eventually backpressured.
- out_valid_o never deasserts without a handshake. Data and flags are held stable while out_valid_o & !out_ready_i.
- Both banks full → in_ready_o = 0 until the reader releases a bank. in_ready_o returns 1 the cycle after release.
- Reset mid-symbol discards everything. The next accepted sample is index 0 of bank 0.

## Structure
- Shared package cp_pkg holds:
  - phase enum (IDLE, CP, BODY)
  - default DW/NFFT/LCP_MAX constants
  - a clog2-based width helper
- One natural sub-module: cp_bank_ram. It is a parametrised 2·DW × NFFT register array with one write port and one combinational read port, and is instantiated twice.

## Test plan
- NFFT=64, cp_len=16, input ramp 0..63 (re = n, im = -n), out_ready=1:
  - output is 48..63 then 0..63 (80 samples)
  - sos on the sample with value 48, eos on the sample with value 63 (second occurrence)
  - first out_valid 1 cycle after the last input accept
- cp_len=0, then cp_len=20 (clamped to 16): first symbol is 64 samples starting at 0; second symbol is 80 samples starting at 48.
- Three back-to-back symbols with out_ready held 0:
  - in_ready drops after 128 accepts
  - releasing out_ready yields 240 gap-free samples in order
- Random out_ready (50%): every sample is held stable while stalled, and the sos/eos count equals the number of symbols.
- flush_i asserted at input sample 30 of symbol 2, while symbol 1 is mid-output:
  - out_valid = 0 next cycle
  - the next full symbol is output correctly with sos set
- RST_I asserted asynchronously mid-CP: outputs go to their reset values immediately, and normal operation resumes after release.
